// File: rtl/fp_pkg.sv
// Shared single-format floating-point definitions for the trig front end.
// Holds field widths, well-known constants, the unpacked operand view and
// the state encoding of the multi-cycle adder.
package fp_pkg;

    localparam int FP_EXP_LEN  = 8;
    localparam int FP_MANT_LEN = 23;
    localparam int FP_WORD_LEN = FP_EXP_LEN + FP_MANT_LEN + 1;
    localparam int FP_SIG_LEN  = FP_MANT_LEN + 1;   // significand incl. hidden bit
    localparam int FP_DP_LEN   = FP_MANT_LEN + 5;   // carry + significand + G/R/S

    localparam int EXP_BIAS = (1 << (FP_EXP_LEN - 1)) - 1;

    localparam logic [FP_MANT_LEN-1:0] PI_MANTISSA = 23'h490FDB;

    localparam logic [FP_WORD_LEN-1:0] CANON_NAN =
        {1'b0, {FP_EXP_LEN{1'b1}}, 1'b1, {(FP_MANT_LEN-1){1'b0}}};
    localparam logic [FP_WORD_LEN-1:0] POS_INF =
        {1'b0, {FP_EXP_LEN{1'b1}}, {FP_MANT_LEN{1'b0}}};
    localparam logic [FP_WORD_LEN-1:0] NEG_INF =
        {1'b1, {FP_EXP_LEN{1'b1}}, {FP_MANT_LEN{1'b0}}};

    typedef struct packed {
        logic                  sign;
        logic [FP_EXP_LEN-1:0] exp;
        logic [FP_SIG_LEN-1:0] mant;   // hidden bit included, zero when flushed
    } fp_unpacked_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        ROUND = 3'd4,
        PACK  = 3'd5
    } add_state_t;

    // Subnormals (exp == 0) are flushed: their significand is forced to zero
    // so they behave as a signed zero in the datapath.
    function automatic fp_unpacked_t fp_unpack(input logic [FP_WORD_LEN-1:0] w);
        fp_unpacked_t u;
        u.sign = w[FP_WORD_LEN-1];
        u.exp  = w[FP_WORD_LEN-2 -: FP_EXP_LEN];
        u.mant = (u.exp == '0) ? '0 : {1'b1, w[FP_MANT_LEN-1:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter.
// Ports:
//   value : input vector, MSB first
//   count : number of zeros above the highest set bit (WIDTH when value == 0)
// Purely combinational.
module fp_lzc
    import fp_pkg::*;
#(
    parameter int WIDTH = FP_DP_LEN,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Scan upward; the highest set bit is the last one to write the count.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_add_responder.sv
// Multi-cycle single-format floating-point adder, responder side of the
// add_start / add_ready handshake used by the trig front-end initiators.
// An operand pair is sampled on add_start; the rounded (nearest-even) sum
// appears on add_sum together with a one-cycle add_ready pulse five clocks
// later. One request is in flight at a time; starts while busy are dropped.
// Ports:
//   clk       : clock, all state changes on the rising edge
//   reset     : synchronous, active-high; aborts any request in flight
//   add_start : one-cycle request strobe, operands valid in the same cycle
//   add_a     : operand A {sign, exp, mantissa}
//   add_b     : operand B {sign, exp, mantissa}
//   add_sum   : registered result, held until the next result
//   add_ready : one-cycle pulse marking a new add_sum
module fp_add_responder
    import fp_pkg::*;
#(
    parameter int EXP_LEN      = FP_EXP_LEN,
    parameter int MANTISSA_LEN = FP_MANT_LEN
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            add_start,
    input  logic [EXP_LEN+MANTISSA_LEN:0]   add_a,
    input  logic [EXP_LEN+MANTISSA_LEN:0]   add_b,
    output logic [EXP_LEN+MANTISSA_LEN:0]   add_sum,
    output logic                            add_ready
);

    localparam int W     = EXP_LEN + MANTISSA_LEN + 1;
    localparam int SIG_W = MANTISSA_LEN + 1;
    localparam int DP_W  = MANTISSA_LEN + 5;
    localparam int RND_W = SIG_W + 1;
    localparam int EW    = EXP_LEN + 2;      // signed exponent with headroom both ways
    localparam int LZC_W = $clog2(DP_W + 1);

    localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_LEN) - 1);

    // Round-to-nearest-even on a normalised value whose leading one sits at
    // the top bit; bits [2:0] are guard, round and sticky. The extra top bit
    // of the result is the mantissa carry-out.
    function automatic logic [RND_W-1:0] round_rne(input logic [DP_W-2:0] v);
        logic lsb;
        logic guard;
        logic sticky;
        lsb    = v[3];
        guard  = v[2];
        sticky = v[1] | v[0];
        return {1'b0, v[DP_W-2:3]} + RND_W'(guard & (sticky | lsb));
    endfunction

    // Saturate a finite result: too large becomes signed infinity, below the
    // smallest normal exponent becomes signed zero.
    function automatic logic [W-1:0] pack_finite(
        input logic                    s,
        input logic signed [EW-1:0]    e,
        input logic [MANTISSA_LEN-1:0] m
    );
        if (e >= EXP_MAX) begin
            return s ? NEG_INF : POS_INF;
        end else if (e < EXP_ONE) begin
            return {s, {(W-1){1'b0}}};
        end else begin
            return {s, e[EXP_LEN-1:0], m};
        end
    endfunction

    add_state_t state;
    add_state_t state_next;
    logic       accept;
    logic       ready_next;

    logic [W-1:0] op_a_p0;
    logic [W-1:0] op_b_p0;

    logic [DP_W-1:0]        big_sig_p1;
    logic [DP_W-1:0]        small_sig_p1;
    logic signed [EW-1:0]   exp_p1;
    logic                   sign_p1;
    logic                   sub_p1;
    logic                   special_p1;
    logic [W-1:0]           special_val_p1;

    logic [DP_W-1:0]        sum_p2;
    logic signed [EW-1:0]   exp_p2;
    logic                   sign_p2;
    logic                   special_p2;
    logic [W-1:0]           special_val_p2;

    logic [DP_W-2:0]        norm_p3;
    logic signed [EW-1:0]   exp_p3;
    logic                   sign_p3;
    logic                   zero_p3;
    logic                   special_p3;
    logic [W-1:0]           special_val_p3;

    logic [MANTISSA_LEN-1:0] mant_p4;
    logic signed [EW-1:0]    exp_p4;
    logic                    sign_p4;
    logic                    zero_p4;
    logic                    special_p4;
    logic [W-1:0]            special_val_p4;

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // PACK also accepts a start so an initiator that issues the next request
    // on the result edge loses no cycle.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ready_next = 1'b0;
        case (state)
            IDLE: begin
                if (add_start) begin
                    accept     = 1'b1;
                    state_next = ALIGN;
                end
            end
            ALIGN: state_next = ADD;
            ADD:   state_next = NORM;
            NORM:  state_next = ROUND;
            ROUND: state_next = PACK;
            PACK: begin
                ready_next = 1'b1;
                if (add_start) begin
                    accept     = 1'b1;
                    state_next = ALIGN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- capture (p0) ----------------
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a_p0 <= add_a;
            op_b_p0 <= add_b;
        end
    end

    // ---------------- align (p0 -> p1) ----------------
    fp_unpacked_t          ua;
    fp_unpacked_t          ub;
    fp_unpacked_t          big;
    logic [EXP_LEN-1:0]    small_exp;
    logic [SIG_W-1:0]      small_mant;
    logic [EXP_LEN-1:0]    exp_diff;
    logic [DP_W-1:0]       small_ext;
    logic [DP_W-1:0]       small_al;
    logic                  a_ge_b;
    logic                  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic                  special_al;
    logic [W-1:0]          special_val_al;

    always_comb begin
        ua         = fp_unpack(op_a_p0);
        ub         = fp_unpack(op_b_p0);
        a_ge_b     = {ua.exp, ua.mant} >= {ub.exp, ub.mant};
        big        = a_ge_b ? ua : ub;
        small_exp  = a_ge_b ? ub.exp  : ua.exp;
        small_mant = a_ge_b ? ub.mant : ua.mant;
        exp_diff   = big.exp - small_exp;
        small_ext  = {1'b0, small_mant, 3'b000};
        // Beyond the guard/round positions only the sticky bit survives.
        if (int'(exp_diff) >= DP_W - 2) begin
            small_al = {{(DP_W-1){1'b0}}, |small_mant};
        end else begin
            small_al    = small_ext >> exp_diff;
            small_al[0] = small_al[0] | (|(small_ext & ~({DP_W{1'b1}} << exp_diff)));
        end
    end

    always_comb begin
        a_nan  = (&op_a_p0[W-2 -: EXP_LEN]) &  (|op_a_p0[MANTISSA_LEN-1:0]);
        b_nan  = (&op_b_p0[W-2 -: EXP_LEN]) &  (|op_b_p0[MANTISSA_LEN-1:0]);
        a_inf  = (&op_a_p0[W-2 -: EXP_LEN]) & ~(|op_a_p0[MANTISSA_LEN-1:0]);
        b_inf  = (&op_b_p0[W-2 -: EXP_LEN]) & ~(|op_b_p0[MANTISSA_LEN-1:0]);
        a_zero = ~(|op_a_p0[W-2 -: EXP_LEN]);
        b_zero = ~(|op_b_p0[W-2 -: EXP_LEN]);
        special_al     = 1'b1;
        special_val_al = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (ua.sign != ub.sign))) begin
            special_val_al = CANON_NAN;
        end else if (a_inf) begin
            special_val_al = op_a_p0;
        end else if (b_inf) begin
            special_val_al = op_b_p0;
        end else if (a_zero && b_zero) begin
            // Only (-0)+(-0) keeps the negative sign.
            special_val_al = {ua.sign & ub.sign, {(W-1){1'b0}}};
        end else begin
            special_al = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        big_sig_p1     <= {1'b0, big.mant, 3'b000};
        small_sig_p1   <= small_al;
        exp_p1         <= $signed({2'b00, big.exp});
        sign_p1        <= big.sign;
        sub_p1         <= ua.sign ^ ub.sign;
        special_p1     <= special_al;
        special_val_p1 <= special_val_al;
    end

    // ---------------- add (p1 -> p2) ----------------
    // The larger magnitude is always on the left, so the difference is
    // never negative.
    always_ff @(posedge clk) begin
        sum_p2         <= sub_p1 ? (big_sig_p1 - small_sig_p1) : (big_sig_p1 + small_sig_p1);
        exp_p2         <= exp_p1;
        sign_p2        <= sign_p1;
        special_p2     <= special_p1;
        special_val_p2 <= special_val_p1;
    end

    // ---------------- normalise (p2 -> p3) ----------------
    logic [LZC_W-1:0]      lzc;
    logic [LZC_W-1:0]      lzc_m1;
    logic [DP_W-2:0]       norm_n;
    logic signed [EW-1:0]  exp_n;

    fp_lzc #(
        .WIDTH (DP_W)
    ) u_lzc (
        .value (sum_p2),
        .count (lzc)
    );

    // Without a carry the leading one belongs one bit below the carry
    // position, hence the shift of lzc-1.
    always_comb begin
        lzc_m1 = lzc - LZC_W'(1);
        if (sum_p2[DP_W-1]) begin
            norm_n = {sum_p2[DP_W-1:2], sum_p2[1] | sum_p2[0]};
            exp_n  = exp_p2 + EXP_ONE;
        end else begin
            norm_n = sum_p2[DP_W-2:0] << lzc_m1;
            exp_n  = exp_p2 - $signed(EW'(lzc_m1));
        end
    end

    always_ff @(posedge clk) begin
        norm_p3        <= norm_n;
        exp_p3         <= exp_n;
        sign_p3        <= sign_p2;
        zero_p3        <= (sum_p2 == '0);
        special_p3     <= special_p2;
        special_val_p3 <= special_val_p2;
    end

    // ---------------- round (p3 -> p4) ----------------
    logic [RND_W-1:0] rounded;

    always_comb begin
        rounded = round_rne(norm_p3);
    end

    // A mantissa carry-out leaves 1.000..0, so the stored field becomes zero
    // and the exponent steps up.
    always_ff @(posedge clk) begin
        mant_p4        <= rounded[SIG_W] ? rounded[MANTISSA_LEN:1] : rounded[MANTISSA_LEN-1:0];
        exp_p4         <= rounded[SIG_W] ? (exp_p3 + EXP_ONE) : exp_p3;
        sign_p4        <= sign_p3;
        zero_p4        <= zero_p3;
        special_p4     <= special_p3;
        special_val_p4 <= special_val_p3;
    end

    // ---------------- pack (p4 -> output) ----------------
    logic [W-1:0] pack_val;

    // Exact cancellation always yields +0.
    always_comb begin
        if (special_p4) begin
            pack_val = special_val_p4;
        end else if (zero_p4) begin
            pack_val = '0;
        end else begin
            pack_val = pack_finite(sign_p4, exp_p4, mant_p4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            add_sum   <= '0;
            add_ready <= 1'b0;
        end else begin
            add_ready <= ready_next;
            if (ready_next) begin
                add_sum <= pack_val;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_responder.sv
module tb_fp_add_responder;

    logic        clk;
    logic        reset;
    logic        add_start;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic        add_ready;

    int checks;
    int errors;

    fp_add_responder dut (
        .clk       (clk),
        .reset     (reset),
        .add_start (add_start),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_ready (add_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact sum as a wide integer in units of 2^-149, then
    // round-to-nearest-even to 24 significant bits.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic        sa, sb, neg;
        int          ea, eb, p, sh;
        logic [22:0] fa, fb;
        logic [299:0] ma, mb, mag, m, rem, half;
        sa = a[31]; ea = int'(a[30:23]); fa = a[22:0];
        sb = b[31]; eb = int'(b[30:23]); fb = b[22:0];
        if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) return 32'h7FC00000;
        if (ea == 255 && eb == 255) return (sa != sb) ? 32'h7FC00000 : a;
        if (ea == 255) return a;
        if (eb == 255) return b;
        if (ea == 0 && eb == 0) return {sa & sb, 31'b0};
        ma = (ea == 0) ? '0 : (300'({1'b1, fa}) << (ea - 1));
        mb = (eb == 0) ? '0 : (300'({1'b1, fb}) << (eb - 1));
        if (sa == sb) begin
            mag = ma + mb; neg = sa;
        end else if (ma >= mb) begin
            mag = ma - mb; neg = sa;
        end else begin
            mag = mb - ma; neg = sb;
        end
        if (mag == '0) return 32'h00000000;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p < 23) return {neg, 31'b0};
        sh = p - 23;
        m = mag >> sh;
        rem = mag - (m << sh);
        if (sh > 0) begin
            half = 300'(1) << (sh - 1);
            if (rem > half || (rem == half && m[0])) m = m + 1;
        end
        if (m[24]) begin
            m = m >> 1;
            sh = sh + 1;
        end
        if (sh + 1 >= 255) return {neg, 8'hFF, 23'b0};
        return {neg, 8'(sh + 1), m[22:0]};
    endfunction

    // Issues one request and waits (bounded) for the ready pulse; lat is the
    // number of edges after the sampling edge, -1 on timeout.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        add_a = a; add_b = b; add_start = 1'b1;
        @(negedge clk);
        add_start = 1'b0;
        add_a = $urandom; add_b = $urandom;
        lat = -1;
        for (int k = 0; k <= 20; k++) begin
            if (add_ready) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        res = add_sum;
    endtask

    task automatic test_reset();
        reset = 1'b1; add_start = 1'b0; add_a = '0; add_b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (add_sum !== 32'h0) begin
            errors++; $display("FAIL reset_sum: got %h want %h", add_sum, 32'h0);
        end
        checks++;
        if (add_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b want 0", add_ready);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (add_ready !== 1'b0) begin
                errors++; $display("FAIL idle_ready: got %b want 0", add_ready);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] da [10];
        logic [31:0] db [10];
        logic [31:0] dx [10];
        logic [31:0] res;
        int lat;
        da = '{32'h3F800000, 32'h40E00000, 32'h3F800000, 32'h3F800000, 32'h40490FDB,
               32'h7F7FFFFF, 32'h7F800000, 32'h80000000, 32'h7FC00001, 32'hFF800000};
        db = '{32'h3F800000, 32'hC0C90FDB, 32'h33800000, 32'h33800001, 32'hC0490FDB,
               32'h7F7FFFFF, 32'hFF800000, 32'h80000000, 32'h3F800000, 32'h3F800000};
        dx = '{32'h40000000, 32'h3F378128, 32'h3F800000, 32'h3F800001, 32'h00000000,
               32'h7F800000, 32'h7FC00000, 32'h80000000, 32'h7FC00000, 32'hFF800000};
        for (int i = 0; i < 10; i++) begin
            run_op(da[i], db[i], res, lat);
            checks++;
            if (lat !== 5) begin
                errors++; $display("FAIL dir_latency[%0d]: got %0d want 5", i, lat);
            end
            checks++;
            if (res !== dx[i]) begin
                errors++; $display("FAIL dir_sum[%0d] %h+%h: got %h want %h", i, da[i], db[i], res, dx[i]);
            end
            @(negedge clk);
            checks++;
            if (add_ready !== 1'b0) begin
                errors++; $display("FAIL dir_pulse[%0d]: ready got %b want 0", i, add_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, want;
        int lat, mode, e;
        for (int n = 0; n < 200; n++) begin
            a = $urandom;
            mode = int'($urandom_range(0, 5));
            case (mode)
                0: b = $urandom;
                1: begin
                    e = int'(a[30:23]) - int'($urandom_range(0, 30));
                    if (e < 1) e = 1;
                    if (e > 254) e = 254;
                    b = {1'($urandom), 8'(e), 23'($urandom)};
                end
                2: b = {~a[31], a[30:23], a[22:0] ^ 23'($urandom_range(0, 15))};
                3: b = {1'($urandom), ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00,
                        ($urandom_range(0, 1) == 1) ? 23'($urandom) : 23'h0};
                4: begin
                    a = {a[31], 8'hFE, a[22:0]};
                    b = {a[31], 8'(254 - int'($urandom_range(0, 2))), 23'($urandom)};
                end
                default: begin
                    e = int'(a[30:23]);
                    if (e < 30) e = 30;
                    if (e > 254) e = 254;
                    a = {a[31], 8'(e), a[22:0]};
                    b = {1'($urandom), 8'(e - 24), 23'h0};
                end
            endcase
            want = ref_add(a, b);
            run_op(a, b, res, lat);
            checks++;
            if (lat !== 5) begin
                errors++; $display("FAIL rnd_latency[%0d]: got %0d want 5", n, lat);
            end
            checks++;
            if (res !== want) begin
                errors++; $display("FAIL rnd_sum[%0d] %h+%h: got %h want %h", n, a, b, res, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r3;
        logic        want_rdy;
        r1 = ref_add(32'h40E00000, 32'h3F800000);
        r3 = ref_add(32'h3F800000, 32'h40000000);
        @(negedge clk);
        add_a = 32'h40E00000; add_b = 32'h3F800000; add_start = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            add_start = 1'b0;
            add_a = $urandom; add_b = $urandom;
            if (c == 1) begin
                add_a = 32'hC0000000; add_b = 32'h3F800000; add_start = 1'b1;
            end
            if (c == 4) begin
                add_a = 32'h3F800000; add_b = 32'h40000000; add_start = 1'b1;
            end
            want_rdy = (c == 5) || (c == 10);
            checks++;
            if (add_ready !== want_rdy) begin
                errors++; $display("FAIL b2b_ready[c=%0d]: got %b want %b", c, add_ready, want_rdy);
            end
            if (c >= 5 && c <= 9) begin
                checks++;
                if (add_sum !== r1) begin
                    errors++; $display("FAIL b2b_sum1[c=%0d]: got %h want %h", c, add_sum, r1);
                end
            end
            if (c >= 10) begin
                checks++;
                if (add_sum !== r3) begin
                    errors++; $display("FAIL b2b_sum2[c=%0d]: got %h want %h", c, add_sum, r3);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r4;
        r4 = ref_add(32'h40490FDB, 32'h40490FDB);
        @(negedge clk);
        add_a = 32'h41200000; add_b = 32'h3F800000; add_start = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            add_start = 1'b0;
            reset = 1'b0;
            if (c == 1) reset = 1'b1;
            if (c == 3) begin
                add_a = 32'h40490FDB; add_b = 32'h40490FDB; add_start = 1'b1;
            end
            checks++;
            if (add_ready !== (c == 9)) begin
                errors++; $display("FAIL abort_ready[c=%0d]: got %b want %b", c, add_ready, (c == 9));
            end
            if (c >= 2 && c <= 8) begin
                checks++;
                if (add_sum !== 32'h0) begin
                    errors++; $display("FAIL abort_sum_cleared[c=%0d]: got %h want 0", c, add_sum);
                end
            end
            if (c >= 9) begin
                checks++;
                if (add_sum !== r4) begin
                    errors++; $display("FAIL abort_next_sum[c=%0d]: got %h want %h", c, add_sum, r4);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
